// File: rtl/spi_slave_sampled.sv
// SPI slave (CPOL=0, CPHA=1, MSB first) with SCLK/CS/MOSI oversampled on clk.
// Word-level system side: data_in latched at CS fall, data_out updated on completion.
module spi_slave_sampled #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  done,
    output logic                  aborted,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  sclk,
    input  logic                  cs
);

    localparam int unsigned CntWidth = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StActive, StWaitCs} state_e;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_prev;
    logic                   sclk_prev;

    // Chains reset to 0 so a CS already low at reset release never looks like a fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise, sclk_fall, sclk_rise;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_fall = sclk_prev & ~sclk_s;
    assign sclk_rise = ~sclk_prev & sclk_s;

    state_e                state;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [CntWidth-1:0]   cnt;

    assign rx_next = {rx_sh[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            rx_sh    <= '0;
            tx_sh    <= '0;
            cnt      <= '0;
            data_out <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            aborted  <= 1'b0;
            miso     <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                StIdle: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        tx_sh <= data_in;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= StActive;
                    end
                end
                StActive: begin
                    // CS rise wins over any coincident SCLK edge, even the completing one.
                    if (cs_rise) begin
                        aborted <= 1'b1;
                        ready   <= 1'b1;
                        miso    <= 1'b0;
                        state   <= StIdle;
                    end else if (sclk_rise) begin
                        miso  <= tx_sh[DATA_WIDTH-1];
                        tx_sh <= tx_sh << 1;
                    end else if (sclk_fall) begin
                        rx_sh <= rx_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LastCnt) begin
                            data_out <= rx_next;
                            done     <= 1'b1;
                            state    <= StWaitCs;
                        end
                    end
                end
                StWaitCs: begin
                    if (cs_rise) begin
                        ready <= 1'b1;
                        miso  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sampled.sv
// Bench for spi_slave_sampled: vector table, corner-case sequences and randomized
// transactions against a word-level model; 8/2 and 16/3 configurations side by side.
module tb_spi_slave_sampled;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  din8, dout8;
    logic        rdy8, done8, ab8, mosi8, miso8, sclk8, cs8;
    logic [15:0] din16, dout16;
    logic        rdy16, done16, ab16, mosi16, miso16, sclk16, cs16;

    spi_slave_sampled #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .data_in(din8), .data_out(dout8), .ready(rdy8),
        .done(done8), .aborted(ab8), .mosi(mosi8), .miso(miso8), .sclk(sclk8), .cs(cs8)
    );

    spi_slave_sampled #(.DATA_WIDTH(16), .SYNC_STAGES(3)) u_dut16 (
        .clk(clk), .rst(rst), .data_in(din16), .data_out(dout16), .ready(rdy16),
        .done(done16), .aborted(ab16), .mosi(mosi16), .miso(miso16), .sclk(sclk16), .cs(cs16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Pulse/edge monitor: counts high cycles of done/aborted, timestamps events.
    int   done8_n = 0, ab8_n = 0, done16_n = 0, ab16_n = 0;
    int   done8_cyc = 0, done16_cyc = 0, rdyfall8_cyc = 0, rdyfall16_cyc = 0;
    logic rdy8_prev = 1'b1, rdy16_prev = 1'b1;
    int   last_csfall_cyc = 0, last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done8) begin done8_n <= done8_n + 1; done8_cyc <= cyc; end
        if (ab8) ab8_n <= ab8_n + 1;
        if (rdy8_prev && !rdy8) rdyfall8_cyc <= cyc;
        rdy8_prev <= rdy8;
        if (done16) begin done16_n <= done16_n + 1; done16_cyc <= cyc; end
        if (ab16) ab16_n <= ab16_n + 1;
        if (rdy16_prev && !rdy16) rdyfall16_cyc <= cyc;
        rdy16_prev <= rdy16;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit wide, input logic c, input logic s, input logic m);
        if (wide) begin cs16 = c; sclk16 = s; mosi16 = m; end
        else begin cs8 = c; sclk8 = s; mosi8 = m; end
    endtask

    function automatic logic get_miso(input bit wide);
        return wide ? miso16 : miso8;
    endfunction

    function automatic logic get_ready(input bit wide);
        return wide ? rdy16 : rdy8;
    endfunction

    function automatic logic [15:0] get_dout(input bit wide);
        return wide ? dout16 : {8'h00, dout8};
    endfunction

    function automatic int get_done_n(input bit wide);
        return wide ? done16_n : done8_n;
    endfunction

    function automatic int get_ab_n(input bit wide);
        return wide ? ab16_n : ab8_n;
    endfunction

    // One master-side CS window: nbits SCLK pulses, MOSI changes on rise, MISO sampled
    // just before each fall. Bits beyond the word length are sent as 1.
    task automatic xfer(input bit wide, input logic [15:0] din, input logic [15:0] din_after,
                        input logic [15:0] mw, input int nbits, input int half,
                        input bit cs_with_last, output logic [31:0] rx);
        int   w    = wide ? 16 : 8;
        int   sync = wide ? 3 : 2;
        logic b;
        if (wide) din16 = din; else din8 = din[7:0];
        @(negedge clk);
        drive(wide, 1'b0, 1'b0, 1'b0);
        last_csfall_cyc = cyc;
        wait_cyc(half);
        check("ready_low_after_cs_fall", {31'd0, get_ready(wide)}, 32'd0);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            b = (i < w) ? mw[w-1-i] : 1'b1;
            drive(wide, 1'b0, 1'b1, b);
            if (i == 2) begin
                if (wide) din16 = din_after; else din8 = din_after[7:0];
            end
            wait_cyc(half);
            rx = {rx[30:0], get_miso(wide)};
            drive(wide, (cs_with_last && i == nbits - 1) ? 1'b1 : 1'b0, 1'b0, b);
            last_fall_cyc = cyc;
            wait_cyc(half);
        end
        if (!cs_with_last || nbits == 0) begin
            check("ready_low_before_cs_rise", {31'd0, get_ready(wide)}, 32'd0);
            drive(wide, 1'b1, 1'b0, 1'b0);
        end
        wait_cyc(sync + 3);
        check("ready_high_after_cs_rise", {31'd0, get_ready(wide)}, 32'd1);
        check("miso_zero_idle", {31'd0, get_miso(wide)}, 32'd0);
    endtask

    // Word-level reference: what the master should see and what data_out should become.
    task automatic model(input int w, input logic [15:0] din, input logic [15:0] mw,
                         input int nbits, input logic [15:0] dout_prev,
                         output logic [31:0] erx, output logic [15:0] edout,
                         output int edone, output int eab);
        erx = '0;
        for (int i = 0; i < nbits; i++)
            erx = {erx[30:0], (i < w) ? din[w-1-i] : din[0]};
        if (nbits >= w) begin
            edout = mw; edone = 1; eab = 0;
        end else begin
            edout = dout_prev; edone = 0; eab = 1;
        end
    endtask

    typedef struct {
        bit          wide;
        logic [15:0] din;
        logic [15:0] din_after;
        logic [15:0] mw;
        int          nbits;
        int          half;
        logic [31:0] exp_rx;
        logic [15:0] exp_dout;
        int          exp_done;
        int          exp_ab;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] rx, erx;
        logic [15:0] edout, ref_dout8, din_r, dina_r, mw_r;
        logic        m;
        int          d0, a0, edone, eab, nb, hf, r, sync;

        vecs[0] = '{0, 16'hA5,   16'hA5,   16'h3C,   8,  4, 32'hA5,   16'h3C,   1, 0};
        vecs[1] = '{0, 16'h5A,   16'h00,   16'h01,   8,  4, 32'h5A,   16'h01,   1, 0};
        vecs[2] = '{0, 16'h00,   16'h00,   16'hFF,   8,  5, 32'h00,   16'hFF,   1, 0};
        vecs[3] = '{0, 16'hC3,   16'hC3,   16'h55,   5,  4, 32'h18,   16'hFF,   0, 1};
        vecs[4] = '{0, 16'h69,   16'h69,   16'hC5,   10, 4, 32'h1A7,  16'hC5,   1, 0};
        vecs[5] = '{1, 16'hBEEF, 16'hBEEF, 16'h1234, 16, 6, 32'hBEEF, 16'h1234, 1, 0};

        rst = 1'b0;
        din8 = '0; din16 = '0;
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        wait_cyc(3);
        check("reset_ready8", {31'd0, rdy8}, 32'd1);
        check("reset_done8", {31'd0, done8}, 32'd0);
        check("reset_miso8", {31'd0, miso8}, 32'd0);
        check("reset_dout8", {24'd0, dout8}, 32'd0);
        check("reset_dout16", {16'd0, dout16}, 32'd0);
        rst = 1'b1;
        wait_cyc(6);

        for (int v = 0; v < 6; v++) begin
            sync = vecs[v].wide ? 4 : 3;
            d0 = get_done_n(vecs[v].wide);
            a0 = get_ab_n(vecs[v].wide);
            xfer(vecs[v].wide, vecs[v].din, vecs[v].din_after, vecs[v].mw, vecs[v].nbits,
                 vecs[v].half, 1'b0, rx);
            check($sformatf("vec%0d_master_rx", v), rx, vecs[v].exp_rx);
            check($sformatf("vec%0d_data_out", v), {16'd0, get_dout(vecs[v].wide)},
                  {16'd0, vecs[v].exp_dout});
            check($sformatf("vec%0d_done_cycles", v), get_done_n(vecs[v].wide) - d0,
                  vecs[v].exp_done);
            check($sformatf("vec%0d_abort_cycles", v), get_ab_n(vecs[v].wide) - a0,
                  vecs[v].exp_ab);
            check($sformatf("vec%0d_ready_fall_latency", v),
                  (vecs[v].wide ? rdyfall16_cyc : rdyfall8_cyc) - last_csfall_cyc, sync);
            if (vecs[v].exp_done == 1 && vecs[v].nbits == (vecs[v].wide ? 16 : 8))
                check($sformatf("vec%0d_done_latency", v),
                      (vecs[v].wide ? done16_cyc : done8_cyc) - last_fall_cyc, sync);
        end

        // Reset in the middle of a transaction, released while CS is still low.
        din8 = 8'h33;
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        wait_cyc(4);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 1'b1, 1'b1); wait_cyc(4);
            drive(0, 1'b0, 1'b0, 1'b1); wait_cyc(4);
        end
        rst = 1'b0;
        #1;
        check("async_reset_ready", {31'd0, rdy8}, 32'd1);
        check("async_reset_dout", {24'd0, dout8}, 32'd0);
        check("async_reset_miso", {31'd0, miso8}, 32'd0);
        wait_cyc(2);
        rst = 1'b1;
        d0 = done8_n; a0 = ab8_n;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, 1'b1, 1'b0); wait_cyc(4);
            drive(0, 1'b0, 1'b0, 1'b0); wait_cyc(4);
        end
        drive(0, 1'b1, 1'b0, 1'b0);
        wait_cyc(6);
        check("rst_mid_no_done", done8_n - d0, 0);
        check("rst_mid_no_abort", ab8_n - a0, 0);
        check("rst_mid_dout", {24'd0, dout8}, 32'd0);
        check("rst_mid_ready", {31'd0, rdy8}, 32'd1);
        d0 = done8_n;
        xfer(0, 16'h81, 16'h81, 16'h77, 8, 4, 1'b0, rx);
        check("post_reset_rx", rx, 32'h81);
        check("post_reset_dout", {24'd0, dout8}, 32'h77);
        check("post_reset_done", done8_n - d0, 1);

        // CS rise coincident with the 8th SCLK fall: abort wins.
        d0 = done8_n; a0 = ab8_n;
        xfer(0, 16'hF0, 16'hF0, 16'hAA, 8, 4, 1'b1, rx);
        check("simul_abort", ab8_n - a0, 1);
        check("simul_no_done", done8_n - d0, 0);
        check("simul_dout_kept", {24'd0, dout8}, 32'h77);
        ref_dout8 = 16'h0077;

        for (int t = 0; t < 25; t++) begin
            din_r  = 16'($urandom_range(0, 255));
            dina_r = 16'($urandom_range(0, 255));
            mw_r   = 16'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r < 6) nb = 8;
            else if (r < 8) nb = $urandom_range(0, 7);
            else nb = $urandom_range(9, 11);
            hf = $urandom_range(4, 6);
            model(8, din_r, mw_r, nb, ref_dout8, erx, edout, edone, eab);
            d0 = done8_n; a0 = ab8_n;
            xfer(0, din_r, dina_r, mw_r, nb, hf, 1'b0, rx);
            check($sformatf("rand%0d_rx", t), rx, erx);
            check($sformatf("rand%0d_dout", t), {24'd0, dout8}, {16'd0, edout});
            check($sformatf("rand%0d_done", t), done8_n - d0, edone);
            check($sformatf("rand%0d_abort", t), ab8_n - a0, eab);
            ref_dout8 = edout;
        end

        m = 1'b0;
        if (m) $display("unreachable");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
